// File: rtl/mem_data_reg_ctl.sv
// mem_data_reg_ctl: memory data register for the multi-cycle CPU datapath.
// Waits for mem_ready after a load request (with timeout), extracts the
// addressed byte/half/word lane, sign- or zero-extends it, and holds the
// result for write-back. Optional macro MDR_BYPASS_EN forwards the
// extracted value combinationally in the cycle mem_ready is seen.
module mem_data_reg_ctl #(
   parameter int DATA_W  = 32,
   parameter int OFF_W   = $clog2(DATA_W/8),
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_req,
   input  logic [2:0]        ld_type,
   input  logic [OFF_W-1:0]  addr_lo,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] mdr_out,
   output logic              mdr_valid,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

   // A load is legal for a known type whose natural alignment is met.
   function automatic logic is_legal(input logic [2:0] t, input logic [OFF_W-1:0] off);
      logic ok;
      case (t)
         3'b000:         ok = (off == '0);
         3'b001, 3'b101: ok = ~off[0];
         3'b010, 3'b110: ok = 1'b1;
         default:        ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Select the addressed lane and extend it to the full data width.
   function automatic logic [DATA_W-1:0] extract(input logic [2:0]        t,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [DATA_W-1:0] d);
      logic signed [7:0]  lane_b;
      logic signed [15:0] lane_h;
      logic [DATA_W-1:0]  r;
      lane_b = 8'(d >> {off, 3'b000});
      lane_h = 16'(d >> {off[OFF_W-1:1], 4'b0000});
      case (t)
         3'b001:  r = {{(DATA_W-16){lane_h[15]}}, lane_h};
         3'b101:  r = {{(DATA_W-16){1'b0}}, lane_h};
         3'b010:  r = {{(DATA_W-8){lane_b[7]}}, lane_b};
         3'b110:  r = {{(DATA_W-8){1'b0}}, lane_b};
         default: r = d;
      endcase
      return r;
   endfunction

   state_t             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [2:0]         type_q, type_d;
   logic [OFF_W-1:0]   off_q, off_d;
   logic [DATA_W-1:0]  mdr_q, mdr_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;

   logic [7:0]         cnt_inc;
   logic [DATA_W-1:0]  extracted;
   logic               capture_now;

   // Wait counter saturates at its maximum instead of wrapping.
   assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
   // Extraction always uses the type/offset latched with the request.
   assign extracted   = extract(type_q, off_q, mem_data);
   assign capture_now = (state_q == S_WAIT) && mem_ready;

   // Next-state and next-output computation for the load handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      type_d  = type_q;
      off_d   = off_q;
      mdr_d   = mdr_q;
      valid_d = valid_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE, S_HOLD: begin
            if (ld_req) begin
               type_d  = ld_type;
               off_d   = addr_lo;
               valid_d = 1'b0;
               if (is_legal(ld_type, addr_lo)) begin
                  state_d = S_WAIT;
                  cnt_d   = 8'd0;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT: begin
            // ld_req is deliberately ignored here: no request queueing.
            if (mem_ready) begin
               mdr_d   = extracted;
               valid_d = 1'b1;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc >= TIMEOUT_L) begin
                  err_d   = 1'b1;
                  valid_d = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_WAIT);
   end

   // State and output registers; async reset returns everything to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         type_q  <= 3'b000;
         off_q   <= '0;
         mdr_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         type_q  <= type_d;
         off_q   <= off_d;
         mdr_q   <= mdr_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

`ifdef MDR_BYPASS_EN
   // Zero-latency forwarding while the capture edge is pending.
   assign mdr_out   = capture_now ? extracted : mdr_q;
   assign mdr_valid = valid_q | capture_now;
`else
   // Purely registered result; capture_now only matters for forwarding.
   assign mdr_out   = mdr_q;
   assign mdr_valid = valid_q | (capture_now & 1'b0);
`endif

   assign busy = busy_q;
   assign err  = err_q;

endmodule

// File: tb/tb_mem_data_reg_ctl.sv
// Self-checking bench for mem_data_reg_ctl (DATA_W=32, TIMEOUT=4).
module tb_mem_data_reg_ctl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_req = 1'b0;
   logic [2:0]  ld_type = 3'b000;
   logic [1:0]  addr_lo = 2'b00;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_data = 32'h0;
   logic [31:0] mdr_out;
   logic        mdr_valid;
   logic        busy;
   logic        err;

   int checks = 0;
   int failures = 0;

   mem_data_reg_ctl #(.DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .ld_type(ld_type),
      .addr_lo(addr_lo), .mem_ready(mem_ready), .mem_data(mem_data),
      .mdr_out(mdr_out), .mdr_valid(mdr_valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Reference: what a load of type t at offset off must return.
   function automatic logic [31:0] mext(input logic [2:0] t, input logic [1:0] off,
                                        input logic [31:0] d);
      logic [31:0] lane;
      lane = d;
      if (t == 3'd1 || t == 3'd5) begin
         lane = (d >> (16 * (int'(off) / 2))) & 32'h0000_FFFF;
         if (t == 3'd1 && lane >= 32'h8000) lane = lane - 32'h1_0000;
      end else if (t == 3'd2 || t == 3'd6) begin
         lane = (d >> (8 * int'(off))) & 32'h0000_00FF;
         if (t == 3'd2 && lane >= 32'h80) lane = lane - 32'h100;
      end
      return lane;
   endfunction

   function automatic bit mlegal(input logic [2:0] t, input logic [1:0] off);
      if (t == 3'd0) return off == 2'd0;
      if (t == 3'd1 || t == 3'd5) return (int'(off) % 2) == 0;
      if (t == 3'd2 || t == 3'd6) return 1'b1;
      return 1'b0;
   endfunction

   // Transaction-level model: a pending load, how long it has waited, result.
   bit        m_pending = 1'b0;
   int        m_waited = 0;
   bit [2:0]  m_type = 3'b0;
   bit [1:0]  m_off = 2'b0;
   bit [31:0] m_out = 32'h0;
   bit        m_valid = 1'b0;
   bit        m_err = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pending <= 1'b0; m_waited <= 0; m_type <= 3'b0; m_off <= 2'b0;
         m_out <= 32'h0; m_valid <= 1'b0; m_err <= 1'b0;
      end else if (m_pending) begin
         if (mem_ready) begin
            m_out <= mext(m_type, m_off, mem_data);
            m_valid <= 1'b1;
            m_pending <= 1'b0;
         end else if (m_waited + 1 >= TO) begin
            m_err <= 1'b1;
            m_valid <= 1'b0;
            m_pending <= 1'b0;
         end else begin
            m_waited <= m_waited + 1;
         end
      end else if (ld_req) begin
         m_valid <= 1'b0;
         if (mlegal(ld_type, addr_lo)) begin
            m_pending <= 1'b1; m_waited <= 0; m_type <= ld_type; m_off <= addr_lo;
         end else begin
            m_err <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cmp_cycle();
      logic [31:0] eo;
      logic        ev;
      eo = m_out;
      ev = m_valid;
`ifdef MDR_BYPASS_EN
      if (m_pending && mem_ready) begin
         eo = mext(m_type, m_off, mem_data);
         ev = 1'b1;
      end
`endif
      chk("cyc_mdr_out", mdr_out, eo);
      chk("cyc_mdr_valid", {31'b0, mdr_valid}, {31'b0, ev});
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_pending});
      chk("cyc_err", {31'b0, err}, {31'b0, m_err});
   endtask

   // Compare the current cycle, then drive the next cycle's inputs.
   task automatic step(input bit req, input logic [2:0] t, input logic [1:0] off,
                       input bit rdy, input logic [31:0] d);
      @(negedge clk);
      cmp_cycle();
      @(posedge clk);
      #1;
      ld_req = req; ld_type = t; addr_lo = off; mem_ready = rdy; mem_data = d;
   endtask

   task automatic idle();
      step(1'b0, 3'b000, 2'b00, 1'b0, 32'h0);
   endtask

   int nb;

   initial begin
      repeat (3) idle();
      rst_n = 1'b1;
      idle();
      #1;
      chk("reset_out", mdr_out, 32'h0);
      chk("reset_valid", {31'b0, mdr_valid}, 32'h0);
      chk("reset_busy", {31'b0, busy}, 32'h0);
      chk("reset_err", {31'b0, err}, 32'h0);

      // Signed byte, mem_ready three cycles after the request.
      step(1'b1, 3'b010, 2'd2, 1'b0, 32'h0);
      idle();
      idle();
      step(1'b0, 3'b000, 2'd0, 1'b1, 32'h1280_FF34);
      idle();
      #1;
      chk("byte_s_out", mdr_out, 32'hFFFF_FF80);
      chk("byte_s_valid", {31'b0, mdr_valid}, 32'h1);
      chk("byte_s_busy", {31'b0, busy}, 32'h0);

      // Unsigned byte; an illegal request during WAIT must be ignored.
      step(1'b1, 3'b110, 2'd2, 1'b0, 32'h0);
      step(1'b1, 3'b011, 2'd0, 1'b0, 32'h0);
      idle();
      step(1'b0, 3'b000, 2'd0, 1'b1, 32'h1280_FF34);
      idle();
      #1;
      chk("byte_u_out", mdr_out, 32'h0000_0080);
      chk("wait_req_ignored_err", {31'b0, err}, 32'h0);

      // Half loads.
      step(1'b1, 3'b001, 2'd2, 1'b0, 32'h0);
      step(1'b0, 3'b000, 2'd0, 1'b1, 32'h8001_7FFF);
      idle();
      #1;
      chk("half_s_out", mdr_out, 32'hFFFF_8001);
      step(1'b1, 3'b101, 2'd0, 1'b0, 32'h0);
      step(1'b0, 3'b000, 2'd0, 1'b1, 32'h8001_7FFF);
      idle();
      #1;
      chk("half_u_out", mdr_out, 32'h0000_7FFF);

      // Back-to-back word from HOLD.
      step(1'b1, 3'b000, 2'd0, 1'b0, 32'h0);
      step(1'b0, 3'b000, 2'd0, 1'b1, 32'hDEAD_BEEF);
      #1;
`ifdef MDR_BYPASS_EN
      chk("b2b_bypass_valid", {31'b0, mdr_valid}, 32'h1);
      chk("b2b_bypass_out", mdr_out, 32'hDEAD_BEEF);
`else
      chk("b2b_gap_valid", {31'b0, mdr_valid}, 32'h0);
      chk("b2b_gap_out", mdr_out, 32'h0000_7FFF);
`endif
      idle();
      #1;
      chk("b2b_out", mdr_out, 32'hDEAD_BEEF);
      chk("b2b_valid", {31'b0, mdr_valid}, 32'h1);

      // Misaligned half from HOLD, then illegal type and misaligned word from IDLE.
      step(1'b1, 3'b001, 2'd1, 1'b0, 32'h0);
      idle();
      #1;
      chk("misalign_err", {31'b0, err}, 32'h1);
      chk("misalign_valid", {31'b0, mdr_valid}, 32'h0);
      chk("misalign_busy", {31'b0, busy}, 32'h0);
      chk("misalign_out", mdr_out, 32'hDEAD_BEEF);
      step(1'b1, 3'b011, 2'd0, 1'b1, 32'h1111_1111);
      step(1'b1, 3'b000, 2'd2, 1'b1, 32'h2222_2222);
      idle();
      #1;
      chk("illegal_busy", {31'b0, busy}, 32'h0);
      chk("illegal_out", mdr_out, 32'hDEAD_BEEF);

      // Asynchronous reset in the middle of WAIT.
      step(1'b1, 3'b010, 2'd1, 1'b0, 32'h0);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out", mdr_out, 32'h0);
      chk("midrst_valid", {31'b0, mdr_valid}, 32'h0);
      chk("midrst_busy", {31'b0, busy}, 32'h0);
      chk("midrst_err", {31'b0, err}, 32'h0);
      idle();
      idle();
      #2;
      rst_n = 1'b1;
      repeat (3) step(1'b0, 3'b000, 2'd0, 1'b1, 32'h1234_5678);
      idle();
      #1;
      chk("postrst_valid", {31'b0, mdr_valid}, 32'h0);
      chk("postrst_out", mdr_out, 32'h0);

      // Timeout: word load with mem_ready held low.
      step(1'b1, 3'b000, 2'd0, 1'b0, 32'h0);
      nb = 0;
      for (int i = 0; i < 6; i++) begin
         idle();
         if (busy) nb++;
      end
      chk("timeout_busy_cycles", nb, TO);
      chk("timeout_err", {31'b0, err}, 32'h1);
      chk("timeout_valid", {31'b0, mdr_valid}, 32'h0);
      step(1'b1, 3'b110, 2'd3, 1'b0, 32'h0);
      step(1'b0, 3'b000, 2'd0, 1'b1, 32'hA500_0000);
      idle();
      #1;
      chk("after_to_out", mdr_out, 32'h0000_00A5);
      chk("after_to_valid", {31'b0, mdr_valid}, 32'h1);
      chk("after_to_err", {31'b0, err}, 32'h1);

      idle();
      idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_data_reg_ctl.md
Name: mem_data_reg_ctl

Overview:
Parametrised memory data register for the multi-cycle CPU datapath. It captures read data from a memory that may insert wait states, handshaking via ld_req/mem_ready with a timeout. It extracts and sign- or zero-extends byte and halfword loads by address offset, then holds the result for the write-back cycle. It sits between data memory and the register-file write-data mux, replacing the unconditional every-cycle capture register.

Parameters:
DATA_W, 32, data width in bits; multiple of 8, 32 or 64
OFF_W, $clog2(DATA_W/8), byte-offset width; derived, do not override
TIMEOUT, 15, maximum wait cycles for mem_ready before abort; 1..255

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_req  in  1  one-cycle pulse from control unit to start a load capture
ld_type  in  3  000 word, 001 half signed, 010 byte signed, 101 half unsigned, 110 byte unsigned
addr_lo  in  OFF_W  low address bits of the load address, sampled with ld_req
mem_ready  in  1  memory data valid this cycle
mem_data  in  DATA_W  raw memory read data
mdr_out  out  DATA_W  registered, extended load result
mdr_valid  out  1  high while mdr_out holds a fresh result
busy  out  1  high in WAIT state
err  out  1  sticky: misaligned access, illegal ld_type, or timeout

Behaviour:
- Reset (rst_n low, async): state IDLE; mdr_out=0, mdr_valid=0, busy=0, err=0; wait counter=0; latched type/offset=0.
- States: IDLE, WAIT, HOLD.
- IDLE: on ld_req, latch ld_type and addr_lo and check legality.
  - Illegal type (011, 100, 111), half with addr_lo[0]=1, or word with addr_lo!=0: set err, stay IDLE, mdr_out unchanged, no capture.
  - Otherwise go to WAIT, busy=1, counter=0.
- WAIT: if mem_ready, capture the extracted value into mdr_out at that edge, set mdr_valid=1 and go to HOLD. Capture latency is 1 cycle from the mem_ready edge.
  - If mem_ready is already high in the ld_req cycle, it is ignored. Data is taken no earlier than the first WAIT cycle.
  - Otherwise increment the counter. When the counter reaches TIMEOUT with no mem_ready: set err, mdr_valid=0, go to IDLE, mdr_out unchanged.
- HOLD: mdr_out stable, mdr_valid=1.
  - A new ld_req performs the same checks as IDLE. If legal: mdr_valid=0 and go to WAIT. If illegal: set err, mdr_valid=0, go to IDLE.
  - With no ld_req, stay in HOLD indefinitely.
- ld_req while in WAIT is ignored; no queueing.
- Extraction:
  - Byte lane = mem_data[8*addr_lo +: 8].
  - Half lane = mem_data[16*addr_lo[OFF_W-1:1] +: 16].
  - Signed types replicate the lane MSB up to DATA_W; unsigned types zero-fill.
  - Word passes mem_data unchanged.
- err is cleared only by reset.
- Reset mid-WAIT: immediate return to IDLE with all outputs at reset values; a later mem_ready is ignored.
- Counter width is 8 bits and saturates; it never wraps.

Optional Feature:
MDR_BYPASS_EN
- Defined: in the cycle WAIT sees mem_ready, mdr_out combinationally presents the extracted value and mdr_valid is driven high in that same cycle, giving zero-latency forwarding. Registered capture still occurs at the edge, so HOLD is unchanged.
- Undefined: mdr_out and mdr_valid are purely registered, as described in Behaviour.

Test Plan:
- Reset mid-operation: rst_n low during WAIT (async, mid-cycle) -> mdr_out=0, mdr_valid=0, busy=0, err=0 immediately; mem_ready after release produces no capture.
- Byte loads: ld_req type=010, addr_lo=2, mem_ready 3 cycles later with mem_data=0x1280_FF34 -> mdr_out=0xFFFF_FF80 one edge after mem_ready, mdr_valid=1, busy=0. Repeat with type=110 -> 0x0000_0080.
- Half load: type=001, addr_lo=2, mem_data=0x8001_7FFF -> 0xFFFF_8001. Type=101, addr_lo=0 -> 0x0000_7FFF.
- Misalignment: type=001, addr_lo=1 -> err=1 next edge, state stays IDLE, mdr_out keeps its previous value, busy never asserts.
- Timeout: TIMEOUT=4, ld_req word with mem_ready held low -> busy for 4 cycles, then err=1, mdr_valid=0, IDLE. A subsequent legal load still completes normally with err remaining 1.
- Back-to-back: in HOLD, ld_req word then mem_ready next cycle with 0xDEAD_BEEF -> mdr_valid drops for exactly 1 cycle, then mdr_out=0xDEAD_BEEF. With MDR_BYPASS_EN, mdr_out shows 0xDEAD_BEEF in the mem_ready cycle itself.
